// File: rtl/sram_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : bus_pkg
// Brief   : Shared state, owner and width constants for the SRAM-like arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_REQ  = REQ,
    ST_RESP = RESP
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int WEN_W      = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

`default_nettype wire

// File: rtl/sram_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : sram_bus_arbiter_if
// Brief   : Bundles the fetch, data and shared memory SRAM-like ports plus flush.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [WEN_W-1:0]  data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              flush;

  logic              mem_req;
  logic              mem_wr;
  logic [WEN_W-1:0]  mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter: serves the core requesters and masters the memory port.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    input  flush,
    output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // The environment: core requesters plus the memory/bridge slave.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    output flush,
    input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_bus_arbiter
// Brief   : Serialises fetch and data requests onto one SRAM-like port, data first.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sram_bus_arbiter_if.slave   bus,
  output logic                busy
);

  state_t            state;
  logic              owner;
  logic              discard;
  logic              req_q;
  logic              wr_q;
  logic [WEN_W-1:0]  wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic is_idle;
  logic take_data;
  logic take_inst;
  logic resp_done;

  assign is_idle   = (state == ST_IDLE);
  assign take_data = ~rst & is_idle & bus.data_req;
  assign take_inst = ~rst & is_idle & ~bus.data_req & bus.inst_req & ~bus.flush;
  assign resp_done = ~rst & (state == ST_RESP) & bus.mem_data_ok;

  assign bus.data_addr_ok = take_data;
  assign bus.inst_addr_ok = take_inst;

  // A flush in the completing cycle also kills the fetch response.
  assign bus.inst_data_ok = resp_done & (owner == OWNER_INST) & ~discard & ~bus.flush;
  assign bus.data_data_ok = resp_done & (owner == OWNER_DATA);

  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;

  assign bus.mem_req   = req_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign busy = ~is_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWNER_INST;
      discard <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          discard <= 1'b0;
          if (bus.data_req) begin
            wr_q    <= bus.data_wr;
            wen_q   <= bus.data_wen;
            addr_q  <= bus.data_addr;
            wdata_q <= bus.data_wdata;
            owner   <= OWNER_DATA;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end else if (bus.inst_req && !bus.flush) begin
            wr_q    <= 1'b0;
            wen_q   <= '0;
            addr_q  <= bus.inst_addr;
            wdata_q <= '0;
            owner   <= OWNER_INST;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The bus handshake still completes after a flush; only the response is dropped.
          if (bus.flush && owner == OWNER_INST) begin
            discard <= 1'b1;
          end
          if (bus.mem_addr_ok) begin
            req_q <= 1'b0;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.flush && owner == OWNER_INST) begin
            discard <= 1'b1;
          end
          if (bus.mem_data_ok) begin
            discard <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction-fetch requester and data-access requester.
- Sits between the mips core and the memory/bridge side.
- Serialises requests with data-over-instruction priority and allows one outstanding transaction.
- Discards an in-flight instruction response when the core flushes on an exception.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
inst_req  input  1  fetch request, held until inst_addr_ok
inst_addr  input  ADDR_W  fetch address
inst_addr_ok  output  1  fetch request accepted (1-cycle pulse)
inst_data_ok  output  1  fetch data valid (1-cycle pulse)
inst_rdata  output  DATA_W  fetch data
data_req  input  1  data request, held until data_addr_ok
data_wr  input  1  1=write, 0=read
data_wen  input  4  byte write enables
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_addr_ok  output  1  data request accepted (pulse)
data_data_ok  output  1  read data valid / write done (pulse)
data_rdata  output  DATA_W  load data
flush  input  1  exception flush from M stage
mem_req  output  1  shared-port request
mem_wr  output  1  shared-port write flag
mem_wen  output  4  shared-port byte enables
mem_addr  output  ADDR_W  shared-port address
mem_wdata  output  DATA_W  shared-port store data
mem_addr_ok  input  1  slave accepted request
mem_data_ok  input  1  slave response valid
mem_rdata  input  DATA_W  slave read data
busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - State is IDLE.
  - mem_req=0, mem_wr=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - owner=INST, discard=0, busy=0.
  - All *_addr_ok and *_data_ok outputs are 0; rdata outputs follow mem_rdata.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If data_req: data_addr_ok=1 combinationally; latch data_wr/data_wen/data_addr/data_wdata; owner=DATA; next state REQ.
  - Else if inst_req & ~flush: inst_addr_ok=1; latch inst_addr with wr=0, wen=0, wdata=0; owner=INST; next state REQ.
  - Data always wins a same-cycle tie. Inst is not accepted in a flush cycle.
- REQ:
  - mem_req=1, driven from the latched registers, which stay stable.
  - On mem_addr_ok, go to RESP. Otherwise hold.
- RESP:
  - mem_req=0.
  - On mem_data_ok, go to IDLE and pulse the owner's *_data_ok combinationally that same cycle.
  - inst_rdata and data_rdata are combinational pass-throughs of mem_rdata.
  - A write response pulses data_data_ok; data_rdata is don't-care.
- Latency:
  - Request seen at cycle t (addr_ok pulse at t).
  - mem_req at t+1.
  - Earliest requester *_data_ok at t+2, when mem_addr_ok arrives at t+1 and mem_data_ok at t+2.
  - The next acceptance occurs no earlier than the cycle after *_data_ok.
- Slave contract:
  - mem_data_ok is only meaningful in RESP and is ignored in IDLE/REQ.
  - mem_addr_ok is ignored outside REQ.
- Flush:
  - When flush=1 and owner=INST in REQ or RESP, set discard=1.
  - The bus transaction still completes: mem_req stays held until addr_ok, per the SRAM-like rule.
  - inst_data_ok is suppressed for that response.
  - discard clears on return to IDLE.
  - Flush never affects a DATA-owned transaction.
  - Flush in IDLE blocks inst acceptance only; data may still be accepted that cycle.
- Reset mid-transaction: immediately returns to IDLE with mem_req=0; the pending response is lost and no *_data_ok is emitted.
- Requester addr_ok is never asserted outside IDLE.
- At most one *_data_ok is high in any cycle.

Decomposition:
- Shared package `bus_pkg`:
  - State encoding localparams: IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - Owner encodings: OWNER_INST=1'b0, OWNER_DATA=1'b1.
  - SRAM-like width constants.
- Single module; no sub-module is natural. The latch register bank is inline.

Test Plan:
- Single fetch: inst_req, addr 0xBFC00000; slave addr_ok at t+1, data_ok with 0x3C080001 at t+2 → inst_addr_ok@t, mem_addr=0xBFC00000, mem_wr=0, inst_data_ok and inst_rdata=0x3C080001 @t+2.
- Tie: inst_req and data_req both high at t, data read of 0x80000010 → data_addr_ok@t, inst_addr_ok=0@t; data completes; inst accepted the cycle after data_data_ok.
- Store byte: data_wr=1, wen=4'b0010, wdata=0x0000AB00, slave holds addr_ok low 3 cycles → mem_req and all mem_* stable for 4 cycles; data_data_ok one pulse on mem_data_ok.
- Flush in RESP: inst owns the transaction; flush=1 one cycle; mem_data_ok two cycles later → inst_data_ok stays 0, FSM returns to IDLE, busy=0.
- Flush in IDLE with inst_req high → inst_addr_ok=0 that cycle; accepted the next cycle once flush=0.
- Reset mid-REQ: assert rst while mem_req=1 → next cycle mem_req=0, busy=0, no data_ok pulse even if mem_data_ok arrives later.
